data_mem_mmio: RTL and testbench
================================

# data_mem_mmio

Data-side memory subsystem for the pipelined RV32 core, sitting directly downstream of the Memory stage. It consumes the core's `MemWriteM` / `ALUResultM` / `WriteDataM` and returns `ReadDataM` in the same cycle. It contains a word-addressed data RAM and a small MMIO register file:
- GPIO output latch
- 64-bit free-running cycle counter
- compare-match timer with interrupt flag

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — RAM depth in 32-bit words; power of two.
- `MMIO_BASE_BIT`, 31 — address bit that selects MMIO (1) versus RAM (0).

Ports:
- `clk`  input  1  — single clock; all state updates on rising edge.
- `reset`  input  1  — asynchronous, active-low; asserting it clears all MMIO state immediately.
- `MemWriteM`  input  1  — write strobe from the Memory stage.
- `ALUResultM`  input  32  — byte address.
- `WriteDataM`  input  32  — store data.
- `ReadDataM`  output  32  — load data; combinational in the address.
- `gpio_o`  output  32  — GPIO_OUT register value.
- `irq_o`  output  1  — timer interrupt, equal to IRQ_FLAG AND IRQ_EN.

## Operation
- Decode: `ALUResultM[MMIO_BASE_BIT]`=0 selects RAM; 1 selects MMIO. `ALUResultM[1:0]` is ignored; all accesses are full words.
- RAM:
  - Index is `ALUResultM[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so accesses alias modulo the depth.
  - Write is synchronous when `MemWriteM`=1. Read is asynchronous.
  - RAM contents are not reset.
- MMIO offsets (`ALUResultM[4:2]`, word offset ×4):
  - 0x00 GPIO_OUT — read/write.
  - 0x04 CYCLE_LO — read-only.
  - 0x08 CYCLE_HI — read-only.
  - 0x0C TIMER_CMP — read/write.
  - 0x10 TIMER_CTRL — bit0 EN, bit1 IRQ_FLAG (write-1-to-clear), bit2 IRQ_EN. Bits [31:3] read 0.
  - 0x14 TIMER_CNT — read/write.
  - 0x18 and 0x1C read 0; writes to them are ignored. Writes to read-only registers are ignored.
- Cycle counter: 64-bit, increments every cycle after reset release and wraps at 2^64. No read snapshot; software handles carry between the two halves.
- Timer, evaluated per cycle in priority order:
  1. A software write to TIMER_CNT loads `WriteDataM`.
  2. Otherwise, if EN=1 and CNT==CMP, CNT loads 0 and IRQ_FLAG is set.
  3. Otherwise, if EN=1, CNT increments by 1 with 32-bit wrap.
  4. EN=0 holds CNT.
- IRQ_FLAG:
  - A hardware set and a software W1C in the same cycle: set wins, flag stays 1.
  - A TIMER_CTRL write updates EN and IRQ_EN from `WriteDataM` and clears the flag only if `WriteDataM[1]`=1.
  - The match check uses pre-write register values. Writing CMP in the same cycle as a match does not suppress that match.

## Timing
- Reset values: GPIO_OUT=0, CYCLE=0, TIMER_CMP=0xFFFF_FFFF, TIMER_CTRL=0, TIMER_CNT=0. Therefore `gpio_o`=0 and `irq_o`=0 during reset.
- Read latency is 0 cycles (combinational).
- A write takes effect at the next rising edge. A same-address read in the write cycle returns the old value.
- The flag sets on the edge where CNT==CMP is observed; `irq_o` rises in the cycle after that edge.
- The match period is CMP+1 cycles.
- Asserting reset mid-operation clears MMIO state asynchronously. After release, the first increment of CYCLE and CNT occurs on the first rising edge with reset high.

## Structure
- Shared package `mmio_pkg`:
  - offset localparams: `OFF_GPIO`, `OFF_CYC_LO`, `OFF_CYC_HI`, `OFF_TCMP`, `OFF_TCTRL`, `OFF_TCNT`
  - TIMER_CTRL bit indices
  - reset constant for TIMER_CMP
- Sub-module `mmio_timer`: holds CNT, CMP, CTRL and the flag logic. Inputs are write strobes and write data; outputs are register values and `irq`.
- The top level contains the RAM array, the address decoder, the cycle counter, GPIO, and the read mux.

## Test plan
- Reset and RAM:
  - Assert reset low → `gpio_o`=0, `irq_o`=0, TIMER_CMP reads 0xFFFF_FFFF.
  - Write 0xDEADBEEF to 0x0000_0010, read it back → 0xDEADBEEF. The same-cycle read during the write returns the prior value.
  - Read 0x0000_1010 with DEPTH_WORDS=1024 → same word (aliasing).
- MMIO decode: write 0xA5 to 0x8000_0000 → `gpio_o`=0xA5 next cycle.
  - Write to 0x8000_0004 → ignored.
  - Read 0x8000_0018 → 0.
- Cycle counter: read CYCLE_LO on two accesses N cycles apart → difference equals N.
  - Force CYCLE_LO to 0xFFFF_FFFF via a bench backdoor, then advance one cycle → CYCLE_HI increments.
- Timer period: set CMP=3, then CTRL=0b101 → IRQ_FLAG sets every 4 cycles and `irq_o` rises one cycle after each match.
  - Write CTRL=0b111 → flag clears.
- Timer same-cycle priority:
  - W1C in the same cycle as a match → flag remains 1.
  - Write CNT=7 in a match cycle → CNT=7, not 0.
- Reset mid-count: assert reset while CNT=2 and EN=1 → CNT=0 and EN=0 immediately; `irq_o` stays 0 after release.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// Purpose: shared constants and types for the data-side memory/MMIO block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   - MMIO word offsets (ALUResultM[4:2])
//   - TIMER_CTRL bit positions and reset constant for TIMER_CMP
//   - timer write-strobe bundle and a helper that packs TIMER_CTRL
package mmio_pkg;

  // Word offsets inside the MMIO window, i.e. byte offset / 4.
  localparam logic [2:0] OFF_GPIO   = 3'd0;  // 0x00
  localparam logic [2:0] OFF_CYC_LO = 3'd1;  // 0x04
  localparam logic [2:0] OFF_CYC_HI = 3'd2;  // 0x08
  localparam logic [2:0] OFF_TCMP   = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_TCTRL  = 3'd4;  // 0x10
  localparam logic [2:0] OFF_TCNT   = 3'd5;  // 0x14

  // TIMER_CTRL bit positions.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLAG  = 1;
  localparam int CTRL_IRQEN = 2;

  // Reset value of TIMER_CMP: the timer would need 2^32 cycles to match.
  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Write strobes from the address decoder into the timer.
  typedef struct packed {
    logic cmp;
    logic ctrl;
    logic cnt;
  } timerWrT;

  // Software view of TIMER_CTRL; upper bits always read as zero.
  function automatic logic [31:0] packCtrl(input logic en, input logic flag,
                                           input logic irqEn);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]    = en;
    w[CTRL_FLAG]  = flag;
    w[CTRL_IRQEN] = irqEn;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Purpose: Memory-stage data bus between the core and data_mem_mmio.
// Latency: read data is combinational in the address; writes land on the next edge.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Signals:
//   MemWriteM  - write strobe            (core -> memory)
//   ALUResultM - byte address            (core -> memory)
//   WriteDataM - store data              (core -> memory)
//   ReadDataM  - load data               (memory -> core)
interface data_mem_mmio_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output ALUResultM,
    output WriteDataM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  ALUResultM,
    input  WriteDataM,
    output ReadDataM
  );
endinterface

// File: rtl/data_mem_mmio_timer.sv
// Purpose: compare-match timer (CNT, CMP, CTRL) with sticky interrupt flag.
// Latency: register updates on the next rising edge; irq is registered state.
// Backpressure: none; write strobes are always accepted.
//
// Ports:
//   clk, reset     - clock and async active-low reset
//   wr, wrData     - per-register write strobes and store data
//   cmp, cnt, ctrl - current register values for the read mux
//   irq            - IRQ_FLAG AND IRQ_EN
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  timerWrT     wr,
  input  logic [31:0] wrData,
  output logic [31:0] cmp,
  output logic [31:0] cnt,
  output logic [31:0] ctrl,
  output logic        irq
);

  logic [31:0] cmpQ;
  logic [31:0] cntQ;
  logic        enQ;
  logic        irqEnQ;
  logic        flagQ;
  logic        match;
  logic        flagClr;

  // Match is judged on the register values before any write in this cycle,
  // so rewriting CMP or disabling EN on a match cycle still lets it fire.
  assign match   = enQ && (cntQ == cmpQ);
  assign flagClr = wr.ctrl && wrData[CTRL_FLAG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmpQ   <= TCMP_RST;
      cntQ   <= '0;
      enQ    <= 1'b0;
      irqEnQ <= 1'b0;
      flagQ  <= 1'b0;
    end else begin
      if (wr.cmp) begin
        cmpQ <= wrData;
      end

      if (wr.ctrl) begin
        enQ    <= wrData[CTRL_EN];
        irqEnQ <= wrData[CTRL_IRQEN];
      end

      // Software load beats the hardware reload on a match cycle.
      if (wr.cnt) begin
        cntQ <= wrData;
      end else if (match) begin
        cntQ <= '0;
      end else if (enQ) begin
        cntQ <= cntQ + 32'd1;
      end

      // Hardware set beats a simultaneous write-1-to-clear.
      if (match) begin
        flagQ <= 1'b1;
      end else if (flagClr) begin
        flagQ <= 1'b0;
      end
    end
  end

  assign cmp  = cmpQ;
  assign cnt  = cntQ;
  assign ctrl = packCtrl(enQ, flagQ, irqEnQ);
  assign irq  = flagQ && irqEnQ;

endmodule

// File: rtl/data_mem_mmio.sv
// Purpose: data RAM plus MMIO (GPIO, 64-bit cycle counter, timer) behind the Memory stage.
// Latency: 0-cycle combinational read; writes take effect on the next rising edge.
// Backpressure: none; the core may issue one access every cycle.
//
// Ports:
//   clk    - single clock
//   reset  - asynchronous active-low reset, clears all MMIO state
//   bus    - data bus slave (MemWriteM / ALUResultM / WriteDataM / ReadDataM)
//   gpio_o - GPIO_OUT register value
//   irq_o  - timer interrupt
module data_mem_mmio
  import mmio_pkg::*;
#(
  parameter int DEPTH_WORDS   = 1024,
  parameter int MMIO_BASE_BIT = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_mmio_if.slave       bus,
  output logic [31:0]          gpio_o,
  output logic                 irq_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic             isMmio;
  logic [2:0]       offs;
  logic [IDX_W-1:0] ramIdx;
  logic             ramWe;
  logic             mmioWe;
  timerWrT          timerWr;
  logic             unusedAddr;

  assign isMmio = bus.ALUResultM[MMIO_BASE_BIT];
  assign offs   = bus.ALUResultM[4:2];
  // Bits above the index are dropped, so RAM aliases modulo its depth.
  assign ramIdx = bus.ALUResultM[IDX_W+1:2];
  assign ramWe  = bus.MemWriteM && !isMmio;
  assign mmioWe = bus.MemWriteM && isMmio;

  // Byte-lane bits and the high address bits do not take part in decode.
  assign unusedAddr = ^bus.ALUResultM;

  assign timerWr.cmp  = mmioWe && (offs == OFF_TCMP);
  assign timerWr.ctrl = mmioWe && (offs == OFF_TCTRL);
  assign timerWr.cnt  = mmioWe && (offs == OFF_TCNT);

  // ---------------------------------------------------------------------
  // Data RAM: synchronous write, asynchronous read, contents not reset
  // ---------------------------------------------------------------------
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ramRd;

  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[ramIdx] <= bus.WriteDataM;
    end
  end

  assign ramRd = ram[ramIdx];

  // ---------------------------------------------------------------------
  // GPIO output latch
  // ---------------------------------------------------------------------
  logic [31:0] gpioQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpioQ <= '0;
    end else if (mmioWe && (offs == OFF_GPIO)) begin
      gpioQ <= bus.WriteDataM;
    end
  end

  assign gpio_o = gpioQ;

  // ---------------------------------------------------------------------
  // Free-running cycle counter; no snapshot, software handles the carry
  // between the two halves.
  // ---------------------------------------------------------------------
  logic [63:0] cycleCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 64'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Compare-match timer
  // ---------------------------------------------------------------------
  logic [31:0] tCmp;
  logic [31:0] tCnt;
  logic [31:0] tCtrl;
  logic        tIrq;

  mmio_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .wr     (timerWr),
    .wrData (bus.WriteDataM),
    .cmp    (tCmp),
    .cnt    (tCnt),
    .ctrl   (tCtrl),
    .irq    (tIrq)
  );

  assign irq_o = tIrq;

  // ---------------------------------------------------------------------
  // Read mux; offsets 0x18 / 0x1C read as zero
  // ---------------------------------------------------------------------
  logic [31:0] mmioRd;

  always_comb begin
    mmioRd = '0;
    case (offs)
      OFF_GPIO:   mmioRd = gpioQ;
      OFF_CYC_LO: mmioRd = cycleCnt[31:0];
      OFF_CYC_HI: mmioRd = cycleCnt[63:32];
      OFF_TCMP:   mmioRd = tCmp;
      OFF_TCTRL:  mmioRd = tCtrl;
      OFF_TCNT:   mmioRd = tCnt;
      default:    mmioRd = '0;
    endcase
  end

  assign bus.ReadDataM = isMmio ? mmioRd : ramRd;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Purpose: self-checking bench for data_mem_mmio (directed cases plus random traffic).
// Latency: outputs compared at the falling edge against a behavioural model.
// Backpressure: n/a.
module tb_data_mem_mmio;

  localparam logic [31:0] A_GPIO  = 32'h8000_0000;
  localparam logic [31:0] A_CYCLO = 32'h8000_0004;
  localparam logic [31:0] A_CYCHI = 32'h8000_0008;
  localparam logic [31:0] A_TCMP  = 32'h8000_000C;
  localparam logic [31:0] A_TCTRL = 32'h8000_0010;
  localparam logic [31:0] A_TCNT  = 32'h8000_0014;
  localparam logic [31:0] A_RES18 = 32'h8000_0018;

  logic        clk;
  logic        rstN;
  logic [31:0] gpio;
  logic        irq;

  data_mem_mmio_if bus ();

  data_mem_mmio #(.DEPTH_WORDS(1024), .MMIO_BASE_BIT(31)) dut (
    .clk    (clk),
    .reset  (rstN),
    .bus    (bus),
    .gpio_o (gpio),
    .irq_o  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  logic [31:0] mem [1024];
  bit          memVld [1024];
  logic [31:0] mGpio, mCmp, mCnt;
  logic [63:0] mCycle;
  logic        mEn, mIrqEn, mFlag;
  logic        bdPend = 1'b0;   // cycle counter was loaded through the backdoor

  function automatic int ramSlot(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic int mmioSlot(input logic [31:0] a);
    return int'((a % 32'd32) / 32'd4);
  endfunction

  function automatic logic [63:0] curCycle();
    return bdPend ? {mCycle[63:32], 32'hFFFF_FFFF} : mCycle;
  endfunction

  // bit 32 = value is known
  function automatic logic [32:0] expRead(input logic [31:0] a);
    logic [63:0] c;
    c = curCycle();
    if (a[31] == 1'b0) begin
      if (memVld[ramSlot(a)]) return {1'b1, mem[ramSlot(a)]};
      return 33'd0;
    end
    case (mmioSlot(a))
      0: return {1'b1, mGpio};
      1: return {1'b1, c[31:0]};
      2: return {1'b1, c[63:32]};
      3: return {1'b1, mCmp};
      4: return {1'b1, 29'd0, mIrqEn, mFlag, mEn};
      5: return {1'b1, mCnt};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // RAM keeps its contents across reset, so it is modelled separately.
  always @(posedge clk) begin
    if (bus.MemWriteM && !bus.ALUResultM[31]) begin
      mem[ramSlot(bus.ALUResultM)]    <= bus.WriteDataM;
      memVld[ramSlot(bus.ALUResultM)] <= 1'b1;
    end
  end

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mGpio  <= 32'd0;
      mCycle <= 64'd0;
      mCmp   <= 32'hFFFF_FFFF;
      mCnt   <= 32'd0;
      mEn    <= 1'b0;
      mIrqEn <= 1'b0;
      mFlag  <= 1'b0;
    end else begin
      logic        hit;
      logic        w;
      int          s;
      logic [31:0] d;
      hit = mEn && (mCnt == mCmp);
      w   = bus.MemWriteM && bus.ALUResultM[31];
      s   = mmioSlot(bus.ALUResultM);
      d   = bus.WriteDataM;
      mCycle <= curCycle() + 64'd1;
      if (w && s == 0) mGpio <= d;
      if (w && s == 3) mCmp <= d;
      if (w && s == 4) begin
        mEn    <= d[0];
        mIrqEn <= d[2];
      end
      if (hit) mFlag <= 1'b1;
      else if (w && s == 4 && d[1]) mFlag <= 1'b0;
      if (w && s == 5) mCnt <= d;
      else if (hit) mCnt <= 32'd0;
      else if (mEn) mCnt <= mCnt + 32'd1;
    end
  end

  // Compare process: every falling edge
  always @(negedge clk) begin
    logic [32:0] e;
    chk("gpio_o", gpio, mGpio);
    chk("irq_o", {31'd0, irq}, {31'd0, mFlag & mIrqEn});
    e = expRead(bus.ALUResultM);
    if (e[32]) chk("ReadDataM", bus.ReadDataM, e[31:0]);
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.MemWriteM  = we;
    bus.ALUResultM = a;
    bus.WriteDataM = d;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v1, v2, h;
    logic [31:0] cv [12];
    logic        iv [12];

    rstN           = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = A_TCMP;
    bus.WriteDataM = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gpio", gpio, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tcmp", bus.ReadDataM, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 rstN = 1'b1;

    // RAM write / same-cycle read / aliasing
    step(1'b1, 32'h0000_0010, 32'h1111_1111);
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ram_old_in_wr", bus.ReadDataM, 32'h1111_1111);
    step(1'b0, 32'h0000_0010, 32'd0);
    chk("ram_rd", bus.ReadDataM, 32'hDEAD_BEEF);
    step(1'b0, 32'h0000_1010, 32'd0);
    chk("ram_alias", bus.ReadDataM, 32'hDEAD_BEEF);

    // MMIO decode
    step(1'b1, A_GPIO, 32'h0000_00A5);
    chk("gpio_old", gpio, 32'd0);
    step(1'b0, A_GPIO, 32'd0);
    chk("gpio_new", gpio, 32'h0000_00A5);
    step(1'b1, A_CYCLO, 32'h0000_1234);
    step(1'b1, A_RES18, 32'hFFFF_FFFF);
    step(1'b1, 32'h8000_001C, 32'hFFFF_FFFF);
    step(1'b0, A_RES18, 32'd0);
    chk("res18", bus.ReadDataM, 32'd0);

    // Cycle counter delta and carry
    step(1'b0, A_CYCLO, 32'd0);
    v1 = bus.ReadDataM;
    repeat (5) step(1'b0, A_CYCLO, 32'd0);
    v2 = bus.ReadDataM;
    chk("cyc_delta", v2 - v1, 32'd5);

    step(1'b0, A_CYCHI, 32'd0);
    h = bus.ReadDataM;
    @(posedge clk);
    #1;
    force dut.cycleCnt = {h, 32'hFFFF_FFFF};
    bdPend = 1'b1;
    bus.ALUResultM = A_CYCLO;
    #1 release dut.cycleCnt;
    @(negedge clk);
    chk("cyc_lo_max", bus.ReadDataM, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    bdPend = 1'b0;
    bus.ALUResultM = A_CYCHI;
    @(negedge clk);
    chk("cyc_hi_carry", bus.ReadDataM, h + 32'd1);
    step(1'b0, A_CYCLO, 32'd0);
    chk("cyc_lo_wrap", bus.ReadDataM, 32'd1);

    // Timer period: CMP=3, EN and IRQ_EN
    step(1'b1, A_TCMP, 32'd3);
    step(1'b1, A_TCTRL, 32'b101);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, A_TCNT, 32'd0);
      cv[i] = bus.ReadDataM;
      iv[i] = irq;
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tcnt_seq%0d", i), cv[i], 32'(i % 4));
      chk($sformatf("irq_seq%0d", i), {31'd0, iv[i]}, {31'd0, (i >= 4)});
    end
    step(1'b1, A_TCTRL, 32'b111);           // cnt=0: plain clear
    step(1'b0, A_TCTRL, 32'd0);
    chk("w1c_clear", bus.ReadDataM, 32'b101);
    step(1'b0, A_TCNT, 32'd0);              // cnt=2
    chk("tcnt_pre", bus.ReadDataM, 32'd2);
    step(1'b1, A_TCTRL, 32'b111);           // cnt=3: match + W1C
    step(1'b0, A_TCTRL, 32'd0);
    chk("w1c_vs_set", bus.ReadDataM, 32'b111);
    step(1'b0, A_TCNT, 32'd0);
    step(1'b0, A_TCNT, 32'd0);
    step(1'b1, A_TCNT, 32'd7);              // cnt=3: match + load
    step(1'b1, A_TCNT, 32'd0);
    chk("load_vs_match", bus.ReadDataM, 32'd7);
    step(1'b0, A_TCNT, 32'd0);
    step(1'b0, A_TCNT, 32'd0);
    step(1'b0, A_TCNT, 32'd0);
    chk("tcnt_two", bus.ReadDataM, 32'd2);

    // Asynchronous reset mid-count
    #2 rstN = 1'b0;
    #1 chk("rst_tcnt_async", bus.ReadDataM, 32'd0);
    bus.ALUResultM = A_TCTRL;
    #1 chk("rst_tctrl_async", bus.ReadDataM, 32'd0);
    chk("rst_irq_async", {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (6) step(1'b0, A_TCNT, 32'd0);
    chk("post_rst_tcnt", bus.ReadDataM, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic        we;
      int          off;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) < 2) begin
        a = ($urandom() & 32'h7FFF_F003) | (32'($urandom_range(0, 63)) << 2);
        d = $urandom();
      end else begin
        off = $urandom_range(0, 7);
        a = 32'h8000_0000 | ($urandom() & 32'h7FFF_FFE3) | (32'(off) << 2);
        if (off == 3 || off == 5) d = 32'($urandom_range(0, 12));
        else if (off == 4) d = $urandom() & 32'h0000_0007;
        else d = $urandom();
      end
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #1;
        rstN = 1'b0;
        bus.MemWriteM = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
      end
      step(we, a, d);
    end

    @(posedge clk);
    #1 bus.MemWriteM = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
